// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the fetch/memory port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Read data returned to the requester when an access is aborted.
    localparam logic [31:0] C_TIMEOUT_DATA = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_timer
// Purpose  : Counts un-acknowledged busy cycles; flags the cycle whose count
//            would reach TIMEOUT so the access can be aborted at that edge.
// Revision : 1.0  initial release
// ============================================================================
module mem_arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] C_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_count_q;
    logic [7:0] w_count_d;

    always_comb begin
        w_count_d = r_count_q;
        if (i_clear) begin
            w_count_d = 8'd0;
        end else if (i_enable) begin
            w_count_d = r_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= 8'd0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_expired = i_enable & ~i_clear & (r_count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between fetch and memory stages with
//            data priority, handshake sequencing, timeout abort and stalls.
//            Optional macro ARB_STARVE_GUARD_EN bounds instruction starvation.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic [DW-1:0] IRData,
    output logic          IValid,
    input  logic          DReq,
    input  logic          DWrite,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWData,
    output logic [DW-1:0] DRData,
    output logic          DValid,
    output logic          StallI,
    output logic          StallD,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    input  logic          MemAck,
    output logic          BusErr
);

    localparam logic [DW-1:0] C_ABORT_DATA = DW'(C_TIMEOUT_DATA);

    if (TIMEOUT < 1 || TIMEOUT > 255 || STARVE_MAX < 1) begin : g_param_check
        $error("mem_port_arbiter: TIMEOUT must be 1..255 and STARVE_MAX >= 1");
    end

    state_e        r_state_q,     w_state_d;
    owner_e        r_owner_q,     w_owner_d;
    logic          r_mem_req_q,   w_mem_req_d;
    logic          r_mem_we_q,    w_mem_we_d;
    logic [AW-1:0] r_mem_addr_q,  w_mem_addr_d;
    logic [DW-1:0] r_mem_wdata_q, w_mem_wdata_d;
    logic [DW-1:0] r_irdata_q,    w_irdata_d;
    logic [DW-1:0] r_drdata_q,    w_drdata_d;
    logic          r_ivalid_q,    w_ivalid_d;
    logic          r_dvalid_q,    w_dvalid_d;
    logic          r_bus_err_q,   w_bus_err_d;

    logic w_busy;
    logic w_expired;
    logic w_grant_d;

    assign w_busy = (r_state_q == IBUSY) || (r_state_q == DBUSY);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (Clock),
        .rst       (Reset),
        .i_clear   (~w_busy),
        .i_enable  (w_busy & ~MemAck),
        .o_expired (w_expired)
    );

`ifdef ARB_STARVE_GUARD_EN
    // Consecutive data grants taken while an instruction fetch was waiting.
    logic [7:0] r_starve_q, w_starve_d;
    logic       w_starve_hit;

    assign w_starve_hit = IReq & (r_starve_q == 8'(STARVE_MAX));
    assign w_grant_d    = DReq & ~w_starve_hit;

    always_comb begin
        w_starve_d = r_starve_q;
        if (r_state_q == IDLE) begin
            if (w_grant_d) begin
                w_starve_d = IReq ? (r_starve_q + 8'd1) : 8'd0;
            end else if (IReq) begin
                w_starve_d = 8'd0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_starve_q <= 8'd0;
        end else begin
            r_starve_q <= w_starve_d;
        end
    end
`else
    assign w_grant_d = DReq;
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_owner_d     = r_owner_q;
        w_mem_req_d   = r_mem_req_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;
        w_irdata_d    = r_irdata_q;
        w_drdata_d    = r_drdata_q;
        w_ivalid_d    = 1'b0;
        w_dvalid_d    = 1'b0;
        w_bus_err_d   = r_bus_err_q;

        case (r_state_q)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_d     = DBUSY;
                    w_owner_d     = OWN_D;
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = DWrite;
                    w_mem_addr_d  = DAddr;
                    w_mem_wdata_d = DWData;
                end else if (IReq) begin
                    w_state_d     = IBUSY;
                    w_owner_d     = OWN_I;
                    w_mem_req_d   = 1'b1;
                    w_mem_we_d    = 1'b0;
                    w_mem_addr_d  = IAddr;
                    w_mem_wdata_d = '0;
                end
            end

            IBUSY, DBUSY: begin
                if (MemAck) begin
                    w_state_d   = DONE;
                    w_mem_req_d = 1'b0;
                    w_mem_we_d  = 1'b0;
                    if (r_owner_q == OWN_I) begin
                        w_irdata_d = MemRData;
                        w_ivalid_d = 1'b1;
                    end else begin
                        w_dvalid_d = 1'b1;
                        if (!r_mem_we_q) begin
                            w_drdata_d = MemRData;
                        end
                    end
                end else if (w_expired) begin
                    // Abort: requester still gets its completion pulse.
                    w_state_d   = DONE;
                    w_mem_req_d = 1'b0;
                    w_mem_we_d  = 1'b0;
                    w_bus_err_d = 1'b1;
                    if (r_owner_q == OWN_I) begin
                        w_irdata_d = C_ABORT_DATA;
                        w_ivalid_d = 1'b1;
                    end else begin
                        w_drdata_d = C_ABORT_DATA;
                        w_dvalid_d = 1'b1;
                    end
                end
            end

            DONE: begin
                w_state_d = IDLE;
            end

            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state_q     <= IDLE;
            r_owner_q     <= OWN_I;
            r_mem_req_q   <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
            r_irdata_q    <= '0;
            r_drdata_q    <= '0;
            r_ivalid_q    <= 1'b0;
            r_dvalid_q    <= 1'b0;
            r_bus_err_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_owner_q     <= w_owner_d;
            r_mem_req_q   <= w_mem_req_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
            r_irdata_q    <= w_irdata_d;
            r_drdata_q    <= w_drdata_d;
            r_ivalid_q    <= w_ivalid_d;
            r_dvalid_q    <= w_dvalid_d;
            r_bus_err_q   <= w_bus_err_d;
        end
    end

    assign MemReq   = r_mem_req_q;
    assign MemWe    = r_mem_we_q;
    assign MemAddr  = r_mem_addr_q;
    assign MemWData = r_mem_wdata_q;
    assign IRData   = r_irdata_q;
    assign DRData   = r_drdata_q;
    assign IValid   = r_ivalid_q;
    assign DValid   = r_dvalid_q;
    assign BusErr   = r_bus_err_q;
    assign StallI   = IReq & ~r_ivalid_q;
    assign StallD   = DReq & ~r_dvalid_q;

endmodule
`default_nettype wire
